// File: rtl/trace_line_sched_pkg.sv
// rtl/trace_line_sched_pkg.sv - shared states, ASCII constants and hex helper for the trace line scheduler
package trace_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_GRANT,
    ST_SEP,
    ST_EOL
  } trace_sched_state_t;

  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NUL   = 8'h00;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/trace_line_sched_if.sv
// rtl/trace_line_sched_if.sv - requester, sink and status bundle of the trace line scheduler
interface trace_line_sched_if #(
  parameter int NREQ = 4
);
  logic              line_start;
  logic              busy;
  logic              overrun;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*8-1:0] req_char;
  logic [NREQ-1:0]   req_last;
  logic              out_val;
  logic              out_rdy;
  logic [7:0]        out_char;
  logic              trunc;
  logic [31:0]       cycles;

  modport master (
    output line_start, req_val, req_char, req_last, out_rdy,
    input  busy, overrun, req_rdy, out_val, out_char, trunc, cycles
  );

  modport slave (
    input  line_start, req_val, req_char, req_last, out_rdy,
    output busy, overrun, req_rdy, out_val, out_char, trunc, cycles
  );
endinterface

// File: rtl/trace_line_sched_prefix.sv
// rtl/trace_line_sched_prefix.sv - six-beat "HHHH: " cycle-stamp sequencer (module trace_sched_prefix)
module trace_sched_prefix
  import trace_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        adv,
  output logic [7:0]  pchar,
  output logic        done
);
  logic [15:0] val_q;
  logic [2:0]  beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
      beat  <= '0;
    end else if (start) begin
      val_q <= value;
      beat  <= '0;
    end else if (adv && beat != 3'd5) begin
      beat <= beat + 3'd1;
    end
  end

  always_comb begin
    pchar = CH_SPACE;
    case (beat)
      3'd0:    pchar = nib2ascii(val_q[15:12]);
      3'd1:    pchar = nib2ascii(val_q[11:8]);
      3'd2:    pchar = nib2ascii(val_q[7:4]);
      3'd3:    pchar = nib2ascii(val_q[3:0]);
      3'd4:    pchar = CH_COLON;
      default: pchar = CH_SPACE;
    endcase
  end

  assign done = adv && (beat == 3'd5);
endmodule

// File: rtl/trace_line_sched.sv
// rtl/trace_line_sched.sv - fixed-order trace line assembler with separators, char budget and newline
// Optional cycle-stamp prefix enabled by defining TRACE_SCHED_CYCLE_PREFIX_EN.
module trace_line_sched
  import trace_sched_pkg::*;
#(
  parameter int          NREQ   = 4,
  parameter int          NCHARS = 512,
  parameter logic [7:0]  SEP    = 8'h7C
) (
  input  logic               clk,
  input  logic               reset,
  trace_line_sched_if.slave  bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NCHARS + 1);
  localparam logic [CW-1:0] CMAX  = CW'(NCHARS - 1);
  localparam logic [GW-1:0] GLAST = GW'(NREQ - 1);

  trace_sched_state_t state, state_nx;
  logic [GW-1:0]   gnt;
  logic [CW-1:0]   cnt;
  logic            trunc_q, overrun_q;
  logic [31:0]     cyc;

  logic            full, drop, fwd, bdrop, gnt_inc, out_val, start_ok;
  logic [7:0]      out_char, gchar;
  logic [NREQ-1:0] rdy_vec;

  assign full     = (cnt >= CMAX);
  assign gchar    = bus.req_char[{gnt, 3'b000} +: 8];
  assign start_ok = (state == ST_IDLE) && bus.line_start;

`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
  logic       pfx_adv, pfx_done;
  logic [7:0] pfx_char;

  trace_sched_prefix u_prefix (
    .clk   (clk),
    .reset (reset),
    .start (start_ok),
    .value (cyc[15:0]),
    .adv   (pfx_adv),
    .pchar (pfx_char),
    .done  (pfx_done)
  );
`endif

  always_comb begin
    state_nx = state;
    out_val  = 1'b0;
    out_char = CH_NUL;
    rdy_vec  = '0;
    drop     = 1'b0;
    fwd      = 1'b0;
    bdrop    = 1'b0;
    gnt_inc  = 1'b0;
`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
    pfx_adv  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
        if (bus.line_start) state_nx = ST_PREFIX;
`else
        if (bus.line_start) state_nx = ST_GRANT;
`endif
      end
`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
      ST_PREFIX: begin
        out_val  = !full;
        out_char = pfx_char;
        pfx_adv  = full || bus.out_rdy;
        if (pfx_adv) begin
          fwd   = !full;
          bdrop = full;
        end
        if (pfx_done) state_nx = ST_GRANT;
      end
`endif
      ST_GRANT: begin
        // NULs are swallowed silently; only budget drops mark the line truncated
        drop         = full || (gchar == CH_NUL);
        out_val      = bus.req_val[gnt] && !drop;
        out_char     = gchar;
        rdy_vec[gnt] = bus.out_rdy || drop;
        if (bus.req_val[gnt] && (bus.out_rdy || drop)) begin
          fwd   = !drop;
          bdrop = full && (gchar != CH_NUL);
          if (bus.req_last[gnt]) state_nx = (gnt == GLAST) ? ST_EOL : ST_SEP;
        end
      end
      ST_SEP: begin
        out_val  = !full;
        out_char = SEP;
        if (full || bus.out_rdy) begin
          fwd      = !full;
          bdrop    = full;
          gnt_inc  = 1'b1;
          state_nx = ST_GRANT;
        end
      end
      ST_EOL: begin
        out_val  = 1'b1;
        out_char = CH_NL;
        if (bus.out_rdy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      cnt       <= '0;
      trunc_q   <= 1'b0;
      overrun_q <= 1'b0;
      cyc       <= '0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc + 32'd1;
      overrun_q <= bus.line_start && (state != ST_IDLE);
      if (start_ok) begin
        gnt     <= '0;
        cnt     <= '0;
        trunc_q <= 1'b0;
      end else begin
        if (gnt_inc) gnt <= gnt + 1'b1;
        if (fwd && !full) cnt <= cnt + 1'b1;
        if (bdrop) trunc_q <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.overrun  = overrun_q;
  assign bus.trunc    = trunc_q;
  assign bus.cycles   = cyc;
  assign bus.out_val  = out_val;
  assign bus.out_char = out_char;
  assign bus.req_rdy  = rdy_vec;
endmodule

// File: tb/tb_trace_line_sched.sv
// tb/tb_trace_line_sched.sv - scoreboard bench: string-level line model vs trace_line_sched
`timescale 1ns/1ps
module tb_trace_line_sched;
  localparam int         NREQ   = 4;
  localparam int         NCHARS = 8;
  localparam logic [7:0] SEPC   = 8'h7C;
`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
  localparam int PFXLEN = 6;
`else
  localparam int PFXLEN = 0;
`endif

  typedef struct {
    byte unsigned ch;
    bit           eol;
    bit           tr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trace_line_sched_if #(.NREQ(NREQ)) bus();
  trace_line_sched #(.NREQ(NREQ), .NCHARS(NCHARS), .SEP(SEPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         exp_q[$];
  byte unsigned frag[NREQ][$];
  byte unsigned fq[NREQ][$];
  bit           rdy_force[$];
  bit           bubbles = 1'b0;
  bit           rdy_rand = 1'b0;
  logic [31:0]  cyc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic byte unsigned hexc(input logic [3:0] n);
    byte unsigned b;
    b = byte'(n);
    return (b < 10) ? byte'(48 + b) : byte'(65 + b - 10);
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) cyc_m <= '0;
    else       cyc_m <= cyc_m + 32'd1;

  // requester and sink driver
  initial begin
    logic [NREQ-1:0] acc;
    bus.req_val  = '0;
    bus.req_char = '0;
    bus.req_last = '0;
    bus.out_rdy  = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.req_val & bus.req_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (reset) fq[i].delete();
        else if (acc[i]) void'(fq[i].pop_front());
        if (fq[i].size() == 0) bus.req_val[i] = 1'b0;
        else if (!bus.req_val[i] || acc[i]) begin
          bus.req_val[i]        = !bubbles || ($urandom_range(3) != 0);
          bus.req_char[i*8 +: 8] = fq[i][0];
          bus.req_last[i]       = (fq[i].size() == 1);
        end
      end
      if (rdy_force.size() != 0) bus.out_rdy = rdy_force.pop_front();
      else bus.out_rdy = !rdy_rand || ($urandom_range(3) != 0);
    end
  end

  // monitor
  initial begin
    bit           held;
    byte unsigned held_ch;
    exp_t         e;
    held = 1'b0;
    held_ch = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        chk("cycles", bus.cycles, cyc_m);
        if (bus.out_val && held) chk("out_char stable while stalled", bus.out_char, held_ch);
        if (bus.out_val && !bus.out_rdy) chk("req_rdy low while stalled", bus.req_rdy, 0);
        if (bus.out_val && bus.out_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected char: got %0h, expected none", bus.out_char);
          end else begin
            e = exp_q.pop_front();
            chk("out_char", bus.out_char, e.ch);
            if (e.eol) chk("trunc at newline", bus.trunc, e.tr);
          end
        end
        held    = bus.out_val && !bus.out_rdy;
        held_ch = bus.out_char;
      end
    end
  end

  // call at a negedge; returns one #1 after the edge that accepts line_start
  task automatic start_line();
    byte unsigned line[$];
    byte unsigned pre[$];
    logic [15:0]  pv;
    bit           t;
    exp_t         e;
    line.delete();
    pre.delete();
    for (int i = 0; i < NREQ; i++) begin
      fq[i] = frag[i];
      foreach (frag[i][k]) if (frag[i][k] != 8'h00) line.push_back(frag[i][k]);
      if (i < NREQ - 1) line.push_back(SEPC);
    end
    @(posedge clk);
    #1;
    pv = cyc_m[15:0];
    if (PFXLEN != 0) begin
      pre = '{hexc(pv[15:12]), hexc(pv[11:8]), hexc(pv[7:4]), hexc(pv[3:0]), 8'h3A, 8'h20};
      line = {pre, line};
    end
    t = (line.size() > NCHARS - 1);
    while (line.size() > NCHARS - 1) void'(line.pop_back());
    foreach (line[k]) begin
      e.ch = line[k]; e.eol = 1'b0; e.tr = 1'b0;
      exp_q.push_back(e);
    end
    e.ch = 8'h0A; e.eol = 1'b1; e.tr = t;
    exp_q.push_back(e);
    bus.line_start = 1'b1;
    @(posedge clk);
    #1;
    bus.line_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " completes"}, (n < 400), 1);
    for (int i = 0; i < NREQ; i++) chk({nm, " all beats acked"}, fq[i].size(), 0);
  endtask

  task automatic set_all(input byte unsigned c);
    for (int i = 0; i < NREQ; i++) frag[i] = '{c};
  endtask

  initial begin
    int n;
    bus.line_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset overrun", bus.overrun, 0);
    chk("reset out_val", bus.out_val, 0);
    chk("reset req_rdy", bus.req_rdy, 0);
    chk("reset trunc", bus.trunc, 0);
    chk("reset cycles", bus.cycles, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
`ifdef TRACE_SCHED_CYCLE_PREFIX_EN
    while (cyc_m < 32'h12B) @(negedge clk);
`endif

    // "F|D|X|W\n" back to back
    frag[0] = '{8'h46}; frag[1] = '{8'h44}; frag[2] = '{8'h58}; frag[3] = '{8'h57};
    start_line();
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("line cycles", n, 8 + PFXLEN);
    wait_done("basic");

    // empty fragment from requester 1
    set_all(8'h41);
    frag[1] = '{8'h00};
    start_line();
    wait_done("nul");

    // budget truncation, then trunc clears on next start
    set_all(8'h5A);
    frag[0] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A};
    start_line();
    wait_done("trunc");
    set_all(8'h51);
    start_line();
    @(negedge clk);
    chk("trunc cleared on start", bus.trunc, 0);
    wait_done("after trunc");

    // sink stall pattern during GRANT
    set_all(8'h59);
    frag[0] = '{8'h50, 8'h51, 8'h52, 8'h53};
    start_line();
    n = 0;
    while (fq[0].size() == 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall setup", (n < 50), 1);
    rdy_force = '{1'b1, 1'b0, 1'b0, 1'b1};
    repeat (4) begin
      @(negedge clk);
      if (bus.out_val && bus.req_val[0] && fq[0].size() != 0)
        chk("req_rdy mirrors out_rdy", bus.req_rdy[0], bus.out_rdy);
    end
    wait_done("stall");

    // overrun while busy
    set_all(8'h4D);
    frag[2] = '{8'h4E, 8'h4F};
    start_line();
    @(negedge clk);
    @(posedge clk);
    #1 bus.line_start = 1'b1;
    @(posedge clk);
    #1 bus.line_start = 1'b0;
    @(negedge clk);
    chk("overrun pulse", bus.overrun, 1);
    @(negedge clk);
    chk("overrun one cycle", bus.overrun, 0);
    wait_done("overrun");

    // randomized lines
    bubbles  = 1'b1;
    rdy_rand = 1'b1;
    for (int l = 0; l < 40; l++) begin
      for (int i = 0; i < NREQ; i++) begin
        frag[i].delete();
        for (int k = 0, len = $urandom_range(1, 3); k < len; k++)
          frag[i].push_back(($urandom_range(5) == 0) ? 8'h00 : byte'(8'h61 + $urandom_range(25)));
      end
      start_line();
      wait_done("random");
    end

    // reset mid-line abandons the line
    bubbles  = 1'b0;
    rdy_rand = 1'b0;
    set_all(8'h52);
    start_line();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid reset out_val", bus.out_val, 0);
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset cycles", bus.cycles, 0);
    chk("mid reset req_rdy", bus.req_rdy, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    set_all(8'h54);
    start_line();
    wait_done("after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global timeout: got no summary, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/trace_line_sched.md
# trace_line_sched

Hardware scheduler that assembles one trace line per request from several pipeline-stage trace sources and serialises it onto a single character stream toward the simulation console / trace sink. It grants requesters in fixed index order so that trace columns stay aligned line to line. It inserts a separator between fragments, enforces the per-line character budget, and terminates each line with a newline. It sits between the per-stage trace formatters and the shared trace output port.

## Interface
- `NREQ`, default 4: number of requesters, 1..16.
- `NCHARS`, default 512: max characters per line, newline included.
- `SEP`, default 8'h7C ('|'): separator inserted between fragments.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  pulse that begins a new line.
- `busy`  out  1  high from the cycle after accepted `line_start` through the newline handshake.
- `overrun`  out  1  one-cycle pulse when `line_start` arrives while busy; that start is ignored.
- `req_val`  in  NREQ  per-requester character valid.
- `req_rdy`  out  NREQ  per-requester character ready.
- `req_char`  in  NREQ*8  per-requester character; requester i uses bits [8i+7:8i].
- `req_last`  in  NREQ  marks the final beat of requester i's fragment.
- `out_val`  out  1  output character valid.
- `out_rdy`  in  1  sink ready.
- `out_char`  out  8  output character.
- `trunc`  out  1  sticky per line; set when any character was dropped for budget.
- `cycles`  out  32  free-running cycle count.

## Operation
- States: IDLE, PREFIX (macro only), GRANT, SEP, EOL.
- IDLE: `line_start` sets `gnt`=0, clears the char count and `trunc`, and moves to PREFIX or GRANT.
- GRANT: only requester `gnt` may be ready.
  - `out_val`=`req_val[gnt]` && !drop.
  - `out_char`=`req_char[gnt]`.
  - `req_rdy[gnt]`=`out_rdy` || drop.
  - drop = char count ≥ NCHARS-1, or `req_char` = 8'h00.
  - NUL beats are consumed, never forwarded, and not counted. A single NUL beat with `req_last` is an empty fragment.
- A beat is accepted when `req_val[gnt]` && `req_rdy[gnt]`. On an accepted beat with `req_last`:
  - if `gnt` < NREQ-1, go to SEP;
  - otherwise go to EOL.
- SEP: emit `SEP`, or drop it if over budget. On handshake (or immediately if dropped), `gnt`++ and return to GRANT.
- EOL: emit 8'h0A, never dropped. On handshake go to IDLE.
- Char count: width $clog2(NCHARS+1); increments once per forwarded character, newline excluded; saturates at NCHARS-1.
- Any character dropped for budget sets `trunc` until the next accepted `line_start`.
- `cycles`: increments every clock, wraps at 2^32, 0 after reset.
- Reset values: state IDLE; `busy`, `overrun`, `out_val`, `req_rdy`, `trunc` = 0; `gnt`=0; `cycles`=0.

## Timing
- `line_start` at edge t → first possible `out_val` in cycle t+1.
- GRANT is a combinational pass-through, so each character costs 1 cycle when the sink is always ready.
- SEP and EOL each take at least 1 cycle; a dropped SEP takes exactly 1 cycle.
- Minimum line time with NREQ single-char fragments, no prefix: 2·NREQ cycles (NREQ chars, NREQ-1 separators, one newline).
- `busy` falls in the cycle after the EOL handshake. `line_start` in that same cycle is accepted.
- Once `out_val` is asserted, `out_char` must not change until the handshake, regardless of requester behaviour. Requesters must therefore hold `req_char` while `req_val` && !`req_rdy`.
- Reset asserted mid-line: all state clears asynchronously; the partial line is abandoned and no newline is emitted.

## Configuration
- `TRACE_SCHED_CYCLE_PREFIX_EN` defined:
  - the PREFIX state exists;
  - on `line_start`, `cycles[15:0]` is latched;
  - emits 4 uppercase hex digits, then ':' and ' ' (6 chars), counted against the budget; then GRANT.
- Undefined: the PREFIX state and latch are compiled out, and IDLE goes directly to GRANT.

## Structure
- Package `trace_sched_pkg` holds:
  - state enum `trace_sched_state_t`;
  - ASCII constants `CH_NL`, `CH_COLON`, `CH_SPACE`, `CH_NUL`;
  - function `nib2ascii`, mapping 4'h0–4'hF to "0"–"9","A"–"F".
- Sub-module `trace_sched_prefix` (instantiated only under the macro): a 6-beat prefix sequencer with start/done and a 3-bit beat counter.

## Test plan
- NREQ=4. Fragments "F", "D", "X", "W" each with last; `out_rdy`=1 → output stream "F|D|X|W\n", 8 cycles, `busy` low on cycle 9.
- Requester 1 sends only 8'h00+last; the others send "A" → "A||A|A\n". The NUL is never visible on `out_char`.
- NCHARS=8. Requester 0 sends "ABCDEFGHIJ" → line "ABCDEFG\n", `trunc`=1; all 10 beats acked. `trunc` clears on the next `line_start`.
- `out_rdy` toggling 1,0,0,1 during GRANT → `out_char` is stable while stalled, and `req_rdy[gnt]` mirrors `out_rdy`.
- `line_start` while busy → `overrun` pulses for 1 cycle and the line is unaffected. `reset` mid-line → next cycle `out_val`=0, `busy`=0, `cycles`=0.
- Macro defined, `line_start` with `cycles`=0x0000_012C → line begins "012C: ".
